alu2_rr_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU2 (ops: arithmetic shift right, logical shift right, sub, add) among NREQ requesters.
- Arbitration is round-robin: one operation is granted per cycle.
- The block drives the ALU operand and op pins, registers the ALU answer, and returns it with the winner's ID over a valid/ready response port.
- Sits between the requester units and a single shared ALU2 instance.

---
 rtl/alu2_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu2_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu2_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU2 among 2**ID_W requesters.
// Define ALU2_ARB_LOCK_EN to add per-requester grant locking (req_lock).

module alu2_arb_lane (
  input  logic       gnt_i,
  input  logic [1:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] c_i,
  output logic [1:0] op_o,
  output logic [3:0] a_o,
  output logic [3:0] b_o,
  output logic [1:0] c_o
);
  // A lane contributes its fields only while granted, so the ALU pins can be
  // formed by OR-ing all lanes together.
  assign op_o = gnt_i ? op_i : 2'b00;
  assign a_o  = gnt_i ? a_i  : 4'h0;
  assign b_o  = gnt_i ? b_i  : 4'h0;
  assign c_o  = gnt_i ? c_i  : 2'b00;
endmodule

module alu2_rr_arbiter #(
  parameter  int ID_W = 2,
  localparam int NREQ = 2**ID_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
`ifdef ALU2_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  input  logic [2*NREQ-1:0] req_op,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_c,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        alu_inA,
  output logic [3:0]        alu_inB,
  output logic [1:0]        alu_inC,
  output logic [1:0]        alu_op,
  input  logic [3:0]        alu_ans,
  output logic              resp_valid,
  output logic [ID_W-1:0]   resp_id,
  output logic [3:0]        resp_data,
  input  logic              resp_ready
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [3:0]      resp_data_q, resp_data_d;
  logic            resp_valid_q, resp_valid_d;
  logic            lock_q, lock_d;

  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] scan_idx;
  logic            stall;
  logic            grant_en;

  logic [NREQ-1:0][1:0] lane_op;
  logic [NREQ-1:0][3:0] lane_a;
  logic [NREQ-1:0][3:0] lane_b;
  logic [NREQ-1:0][1:0] lane_c;

  assign stall    = resp_valid_q & ~resp_ready;
  assign grant_en = ~reset & ~stall & (|req);

  // Scan from ptr upward; iterating offsets high-to-low lets the nearest
  // requesting index overwrite the others. ID_W-bit sums wrap mod NREQ.
  always_comb begin
    winner   = ptr_q;
    scan_idx = ptr_q;
    for (int k = NREQ-1; k >= 0; k--) begin
      scan_idx = ptr_q + ID_W'(k);
      if (req[scan_idx]) winner = scan_idx;
    end
`ifdef ALU2_ARB_LOCK_EN
    if (lock_q && req[resp_id_q] && req_lock[resp_id_q]) winner = resp_id_q;
`endif
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++)
      gnt[i] = grant_en && (winner == ID_W'(i));
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    alu2_arb_lane u_lane (
      .gnt_i (gnt[g]),
      .op_i  (req_op[2*g +: 2]),
      .a_i   (req_a[4*g +: 4]),
      .b_i   (req_b[4*g +: 4]),
      .c_i   (req_c[2*g +: 2]),
      .op_o  (lane_op[g]),
      .a_o   (lane_a[g]),
      .b_o   (lane_b[g]),
      .c_o   (lane_c[g])
    );
  end

  always_comb begin
    alu_op  = '0;
    alu_inA = '0;
    alu_inB = '0;
    alu_inC = '0;
    for (int i = 0; i < NREQ; i++) begin
      alu_op  = alu_op  | lane_op[i];
      alu_inA = alu_inA | lane_a[i];
      alu_inB = alu_inB | lane_b[i];
      alu_inC = alu_inC | lane_c[i];
    end
  end

  // A stall holds everything, including any lock, until the response drains.
  always_comb begin
    ptr_d        = ptr_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    lock_d       = lock_q;
    if (grant_en) begin
      resp_data_d  = alu_ans;
      resp_id_d    = winner;
      resp_valid_d = 1'b1;
      ptr_d        = winner + ID_W'(1);
`ifdef ALU2_ARB_LOCK_EN
      lock_d       = req_lock[winner];
`else
      lock_d       = 1'b0;
`endif
    end else if (!stall) begin
      resp_valid_d = 1'b0;
      lock_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      lock_q       <= lock_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_alu2_rr_arbiter.sv
// Bench for alu2_rr_arbiter: directed vectors plus a cycle-level reference model.
module tb_alu2_rr_arbiter;
  localparam int ID_W = 2;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [2*NREQ-1:0] req_op = '0;
  logic [4*NREQ-1:0] req_a = '0;
  logic [4*NREQ-1:0] req_b = '0;
  logic [2*NREQ-1:0] req_c = '0;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        alu_inA, alu_inB, alu_ans;
  logic [1:0]        alu_inC, alu_op;
  logic              resp_valid;
  logic [ID_W-1:0]   resp_id;
  logic [3:0]        resp_data;
  logic              resp_ready = 1'b1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu2_rr_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req(req),
`ifdef ALU2_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .gnt(gnt), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC),
    .alu_op(alu_op), .alu_ans(alu_ans), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] c, input logic [1:0] op);
    logic signed [3:0] sa;
    sa = a;
    case (op)
      2'd0:    begin sa = sa >>> c; return sa; end
      2'd1:    return a >> c;
      2'd2:    return a - b;
      default: return a + b;
    endcase
  endfunction

  assign alu_ans = alu_f(alu_inA, alu_inB, alu_inC, alu_op);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: pointer, response register, lock owner.
  int         m_ptr, m_id, w, idx;
  logic       m_valid, m_lock, m_stall;
  logic [3:0] m_data, ea, eb, eg;
  logic [1:0] eo, ec;

  always @(negedge clk) begin
    if (reset) begin
      m_ptr = 0; m_id = 0; m_data = 0; m_valid = 0; m_lock = 0;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_valid", int'(resp_valid), 0);
      chk("rst_id", int'(resp_id), 0);
      chk("rst_data", int'(resp_data), 0);
    end else begin
      m_stall = m_valid && !resp_ready;
      w = -1;
      if (!m_stall && req != 0) begin
`ifdef ALU2_ARB_LOCK_EN
        if (m_lock && req[m_id] && req_lock[m_id]) w = m_id;
`endif
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req[idx]) w = idx;
        end
      end
      eg = 0; ea = 0; eb = 0; ec = 0; eo = 0;
      if (w >= 0) begin
        eg[w] = 1'b1;
        ea = req_a[4*w +: 4]; eb = req_b[4*w +: 4];
        ec = req_c[2*w +: 2]; eo = req_op[2*w +: 2];
      end
      chk("gnt", int'(gnt), int'(eg));
      chk("alu_inA", int'(alu_inA), int'(ea));
      chk("alu_inB", int'(alu_inB), int'(eb));
      chk("alu_inC", int'(alu_inC), int'(ec));
      chk("alu_op", int'(alu_op), int'(eo));
      chk("resp_valid", int'(resp_valid), int'(m_valid));
      chk("resp_id", int'(resp_id), m_id);
      chk("resp_data", int'(resp_data), int'(m_data));
      if (w >= 0) begin
        m_valid = 1; m_id = w; m_data = alu_f(ea, eb, ec, eo);
        m_ptr = (w + 1) % NREQ;
        m_lock = req_lock[w];
`ifndef ALU2_ARB_LOCK_EN
        m_lock = 0;
`endif
      end else if (!m_stall) begin
        m_valid = 0; m_lock = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_lock = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] c);
    req_op[2*i +: 2] = op; req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;   req_c[2*i +: 2] = c;
  endtask

  initial begin
    // Reset: grant suppressed even with a request pending.
    req = 4'b0001;
    set_req(0, 2'b11, 4'd7, 4'd9, 2'd0);
    #2 chk("T1 gnt in reset", int'(gnt), 0);
    chk("T1 valid in reset", int'(resp_valid), 0);
    step();
    reset = 1'b0;
    #1 chk("T1 gnt", int'(gnt), 4'b0001);
    chk("T1 alu_inA", int'(alu_inA), 7);
    step();
    chk("T1 valid", int'(resp_valid), 1);
    chk("T1 id", int'(resp_id), 0);
    chk("T1 data 7+9", int'(resp_data), 0);
    req = '0;
    #1 chk("T1 idle gnt", int'(gnt), 0);
    step();
    chk("T1 valid drop", int'(resp_valid), 0);

    // Full-load rotation from ptr=0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b11, 4'(i), 4'd3, 2'd0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("T2 gnt", int'(gnt), 1 << (k % 4));
      step();
      chk("T2 id", int'(resp_id), k % 4);
      chk("T2 data", int'(resp_data), (k % 4) + 3);
    end

    // ALU op coverage through requester 2.
    req = 4'b0100;
    set_req(2, 2'b00, 4'b1000, 4'd0, 2'd2);
    #1 chk("T3 gnt", int'(gnt), 4'b0100);
    step();
    chk("T3 asr", int'(resp_data), 4'b1110);
    chk("T3 id", int'(resp_id), 2);
    set_req(2, 2'b01, 4'b1000, 4'd0, 2'd2);
    step();
    chk("T3 lsr", int'(resp_data), 4'b0010);
    set_req(2, 2'b10, 4'd3, 4'd5, 2'd0);
    step();
    chk("T3 sub", int'(resp_data), 4'b1110);

    // Back-pressure: response held, no grants, then same-cycle regrant.
    resp_ready = 1'b0;
    req = 4'b0010;
    set_req(1, 2'b11, 4'd5, 4'd6, 2'd0);
    #1 chk("T4 stall gnt", int'(gnt), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("T4 hold gnt", int'(gnt), 0);
      chk("T4 hold valid", int'(resp_valid), 1);
      chk("T4 hold data", int'(resp_data), 4'b1110);
      chk("T4 hold id", int'(resp_id), 2);
    end
    resp_ready = 1'b1;
    #1 chk("T4 release gnt", int'(gnt), 4'b0010);
    step();
    chk("T4 id", int'(resp_id), 1);
    chk("T4 data", int'(resp_data), 11);

    // Asynchronous reset mid-stream.
    #2 reset = 1'b1;
    #1 chk("T5 async valid", int'(resp_valid), 0);
    chk("T5 async gnt", int'(gnt), 0);
    step();
    reset = 1'b0;
    req = 4'b1001;
    set_req(0, 2'b11, 4'd2, 4'd2, 2'd0);
    set_req(3, 2'b01, 4'd15, 4'd0, 2'd1);
    #1 chk("T5 gnt ptr0", int'(gnt), 4'b0001);
    step();
    chk("T5 id", int'(resp_id), 0);
    chk("T5 data", int'(resp_data), 4);
    chk("T5 gnt next", int'(gnt), 4'b1000);
    step();
    chk("T5 data3", int'(resp_data), 7);
    req = '0;
    step();

`ifdef ALU2_ARB_LOCK_EN
    // Lock keeps requester 1 ahead of the rotation until released.
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0111; req_lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1 chk("T6 locked gnt", int'(gnt), 4'b0010);
      step();
    end
    req_lock = '0;
    #1 chk("T6 unlock gnt", int'(gnt), 4'b0100);
    step();
    req = '0;
    step();
`endif

    // Mixed traffic with random back-pressure, checked by the model.
    for (int k = 0; k < 60; k++) begin
      req = 4'($urandom_range(0, 15));
      req_lock = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      req_op = 8'($urandom); req_c = 8'($urandom);
      req_a = 16'($urandom); req_b = 16'($urandom);
      step();
    end
    req = '0; resp_ready = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
